// File: rtl/spike_rate_lp_mc.sv
// Multi-channel spike-rate low-pass filter: one shared leak/gain datapath sweeps
// the channels after each accepted tick, with saturation, overrun and readback.
module spike_rate_lp_mc #(
  parameter int N_CH = 8,
  parameter int W    = 16,
  parameter int GAIN = 256,
  parameter int AW   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clk_en,
  input  logic                   clear_i,
  input  logic [N_CH-1:0]        spike_i,
  input  logic [N_CH*AW-1:0]     alpha_i,
  input  logic [$clog2(N_CH):0]  rd_ch_i,
  output logic [W-1:0]           rd_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   overrun_o,
  output logic [N_CH-1:0]        sat_o
);
  localparam int IW = $clog2(N_CH);
  localparam int CW = IW + 1;
  localparam logic [W:0] GAIN_X = (W+1)'(GAIN);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t                 r_state;
  logic [N_CH-1:0][W-1:0] r_y;
  logic [N_CH-1:0]        r_pend;
  logic [N_CH-1:0]        r_acc;
  logic [IW-1:0]          r_idx;

  logic [N_CH-1:0][AW-1:0] w_alpha;
  logic [W-1:0]            w_y;
  logic [W-1:0]            w_leak;
  logic [W:0]              w_sum;
  logic [W-1:0]            w_y_nxt;
  logic                    w_rd_ok;
  logic [W-1:0]            w_rd;

  // y - (y >> a) cannot underflow, so only the gain add can overflow into bit W
  assign w_alpha = alpha_i;
  assign w_y     = r_y[r_idx];
  assign w_leak  = w_y >> w_alpha[r_idx];
  assign w_sum   = {1'b0, w_y - w_leak} + (r_pend[r_idx] ? GAIN_X : '0);
  assign w_y_nxt = w_sum[W] ? {W{1'b1}} : w_sum[W-1:0];

  assign w_rd_ok = rd_ch_i < CW'(N_CH);
  assign w_rd    = w_rd_ok ? r_y[rd_ch_i[IW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_y       <= '0;
      r_pend    <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
      sat_o     <= '0;
      rd_data_o <= '0;
    end else begin
      done_o    <= 1'b0;
      rd_data_o <= w_rd;
      if (clear_i) begin
        r_state   <= S_IDLE;
        r_y       <= '0;
        r_pend    <= '0;
        r_acc     <= '0;
        r_idx     <= '0;
        busy_o    <= 1'b0;
        overrun_o <= 1'b0;
        sat_o     <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (clk_en) begin
              r_pend  <= spike_i | r_acc;
              r_acc   <= '0;
              r_idx   <= '0;
              busy_o  <= 1'b1;
              r_state <= S_SWEEP;
            end
          end
          S_SWEEP: begin
            r_y[r_idx] <= w_y_nxt;
            if (w_sum[W]) sat_o[r_idx] <= 1'b1;
            // ticks landing mid-sweep are folded into the next accepted tick
            if (clk_en) begin
              overrun_o <= 1'b1;
              r_acc     <= r_acc | spike_i;
            end
            if (r_idx == IW'(N_CH-1)) begin
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spike_rate_lp_mc.sv
// Directed bench for spike_rate_lp_mc (N_CH=8, W=16, GAIN=256, AW=4).
module tb_spike_rate_lp_mc;
  localparam int N_CH = 8;
  localparam int W    = 16;
  localparam int AW   = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clk_en = 1'b0;
  logic                 clear_i = 1'b0;
  logic [N_CH-1:0]      spike_i = '0;
  logic [N_CH*AW-1:0]   alpha_i = {N_CH{4'd4}};
  logic [3:0]           rd_ch_i = '0;
  logic [W-1:0]         rd_data_o;
  logic                 busy_o, done_o, overrun_o;
  logic [N_CH-1:0]      sat_o;

  int ntests = 0;
  int nfail  = 0;

  spike_rate_lp_mc #(.N_CH(N_CH), .W(W), .GAIN(256), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .clear_i(clear_i),
    .spike_i(spike_i), .alpha_i(alpha_i), .rd_ch_i(rd_ch_i),
    .rd_data_o(rd_data_o), .busy_o(busy_o), .done_o(done_o),
    .overrun_o(overrun_o), .sat_o(sat_o)
  );

  always #5 clk = ~clk;

  // Presents a tick for exactly one edge; returns 1 time unit after that edge.
  task automatic tick(input logic [N_CH-1:0] sp);
    clk_en  = 1'b1;
    spike_i = sp;
    @(posedge clk); #1;
    clk_en  = 1'b0;
    spike_i = '0;
  endtask

  // Cycles from the tick edge until done_o is seen; -1 when the bound expires.
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done_o) begin n = i; break; end
    end
  endtask

  task automatic read_ch(input int ch, output logic [W-1:0] v);
    rd_ch_i = 4'(ch);
    @(posedge clk); #1;
    v = rd_data_o;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    ntests++; if ({busy_o, done_o, overrun_o} !== 3'b000) begin nfail++;
      $display("FAIL reset_flags got %b want 000", {busy_o, done_o, overrun_o}); end
    ntests++; if (sat_o !== 8'h00) begin nfail++;
      $display("FAIL reset_sat got %h want 00", sat_o); end
    read_ch(0, v);
    ntests++; if (v !== 16'd0) begin nfail++;
      $display("FAIL reset_rd got %0d want 0", v); end
  endtask

  task automatic test_basic();
    logic [W-1:0] v;
    int n;
    alpha_i = {N_CH{4'd4}};
    tick(8'h01);
    wait_done(n);
    ntests++; if (n !== 8) begin nfail++;
      $display("FAIL basic_done_latency got %0d want 8", n); end
    @(posedge clk); #1;
    ntests++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin nfail++;
      $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done_o, busy_o); end
    read_ch(0, v);
    ntests++; if (v !== 16'd256) begin nfail++;
      $display("FAIL basic_ch0_first got %0d want 256", v); end
    read_ch(1, v);
    ntests++; if (v !== 16'd0) begin nfail++;
      $display("FAIL basic_ch1 got %0d want 0", v); end
    tick(8'h00); wait_done(n);
    read_ch(0, v);
    ntests++; if (v !== 16'd240 || n !== 8) begin nfail++;
      $display("FAIL basic_ch0_decay1 got %0d/%0d want 240/8", v, n); end
    tick(8'h00); wait_done(n);
    read_ch(0, v);
    ntests++; if (v !== 16'd225 || n !== 8) begin nfail++;
      $display("FAIL basic_ch0_decay2 got %0d/%0d want 225/8", v, n); end
  endtask

  task automatic test_sat();
    logic [W-1:0] v;
    int n, tmo;
    tmo = 0;
    do_clear();
    alpha_i = {N_CH{4'd4}};
    alpha_i[3*AW +: AW] = 4'd15;
    for (int k = 0; k < 128; k++) begin tick(8'h08); wait_done(n); if (n < 0) tmo++; end
    read_ch(3, v);
    ntests++; if (v !== 16'd32768) begin nfail++;
      $display("FAIL sat_k128 got %0d want 32768", v); end
    tick(8'h08); wait_done(n); if (n < 0) tmo++;
    read_ch(3, v);
    ntests++; if (v !== 16'd33023 || sat_o !== 8'h00) begin nfail++;
      $display("FAIL sat_k129 got %0d sat=%h want 33023 sat=00", v, sat_o); end
    for (int k = 129; k < 256; k++) begin tick(8'h08); wait_done(n); if (n < 0) tmo++; end
    read_ch(3, v);
    ntests++; if (v !== 16'd65408 || sat_o !== 8'h00) begin nfail++;
      $display("FAIL sat_k256 got %0d sat=%h want 65408 sat=00", v, sat_o); end
    tick(8'h08); wait_done(n); if (n < 0) tmo++;
    read_ch(3, v);
    ntests++; if (v !== 16'hFFFF || sat_o !== 8'h08) begin nfail++;
      $display("FAIL sat_clamp got %0d sat=%h want 65535 sat=08", v, sat_o); end
    tick(8'h08); wait_done(n); if (n < 0) tmo++;
    read_ch(3, v);
    ntests++; if (v !== 16'hFFFF || sat_o !== 8'h08) begin nfail++;
      $display("FAIL sat_hold got %0d sat=%h want 65535 sat=08", v, sat_o); end
    ntests++; if (tmo !== 0) begin nfail++;
      $display("FAIL sat_timeouts got %0d want 0", tmo); end
  endtask

  task automatic test_overrun();
    logic [W-1:0] v;
    int n;
    do_clear();
    alpha_i = {N_CH{4'd4}};
    tick(8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tick(8'h80);
    wait_done(n);
    ntests++; if (overrun_o !== 1'b1 || n !== 5) begin nfail++;
      $display("FAIL ovr_flag got ovr=%b n=%0d want 1 5", overrun_o, n); end
    read_ch(7, v);
    ntests++; if (v !== 16'd0) begin nfail++;
      $display("FAIL ovr_ch7_first got %0d want 0", v); end
    tick(8'h00); wait_done(n);
    read_ch(7, v);
    ntests++; if (v !== 16'd256 || overrun_o !== 1'b1) begin nfail++;
      $display("FAIL ovr_ch7_acc got %0d ovr=%b want 256 1", v, overrun_o); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] v;
    int bad;
    bad = 0;
    tick(8'hFF);
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    ntests++; if ({busy_o, done_o, overrun_o} !== 3'b000 || sat_o !== 8'h00 || rd_data_o !== 16'd0) begin
      nfail++;
      $display("FAIL rstmid_async got b/d/o=%b sat=%h rd=%0d want 000 00 0",
               {busy_o, done_o, overrun_o}, sat_o, rd_data_o);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int c = 0; c < N_CH; c++) begin read_ch(c, v); if (v !== 16'd0) bad++; end
    ntests++; if (bad !== 0 || busy_o !== 1'b0) begin nfail++;
      $display("FAIL rstmid_rates got %0d nonzero busy=%b want 0 0", bad, busy_o); end
  endtask

  task automatic test_clear();
    logic [W-1:0] v;
    int n, bad, seen;
    alpha_i = {N_CH{4'd4}};
    tick(8'hFF); wait_done(n);
    tick(8'hFF);
    @(posedge clk); #1;
    tick(8'hFF);
    @(posedge clk); #1;
    clear_i = 1'b1; clk_en = 1'b1; spike_i = 8'hFF;
    @(posedge clk); #1;
    clear_i = 1'b0; clk_en = 1'b0; spike_i = '0;
    ntests++; if ({busy_o, overrun_o} !== 2'b00 || sat_o !== 8'h00) begin nfail++;
      $display("FAIL clr_flags got busy/ovr=%b sat=%h want 00 00", {busy_o, overrun_o}, sat_o); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin @(posedge clk); #1; if (done_o || busy_o) seen++; end
    ntests++; if (seen !== 0) begin nfail++;
      $display("FAIL clr_no_done got %0d active cycles want 0", seen); end
    bad = 0;
    for (int c = 0; c < N_CH; c++) begin read_ch(c, v); if (v !== 16'd0) bad++; end
    ntests++; if (bad !== 0) begin nfail++;
      $display("FAIL clr_rates got %0d nonzero want 0", bad); end
    tick(8'h00); wait_done(n);
    bad = 0;
    for (int c = 0; c < N_CH; c++) begin read_ch(c, v); if (v !== 16'd0) bad++; end
    ntests++; if (bad !== 0 || n !== 8) begin nfail++;
      $display("FAIL clr_acc_flushed got %0d nonzero n=%0d want 0 8", bad, n); end
  endtask

  task automatic test_readback();
    logic [W-1:0] v;
    int n;
    do_clear();
    alpha_i = {N_CH{4'd4}};
    tick(8'h06); wait_done(n);
    read_ch(9, v);
    ntests++; if (v !== 16'd0) begin nfail++;
      $display("FAIL rd_oob got %0d want 0", v); end
    read_ch(1, v);
    ntests++; if (v !== 16'd256) begin nfail++;
      $display("FAIL rd_ch1 got %0d want 256", v); end
    rd_ch_i = 4'd2;
    @(posedge clk); #1;
    tick(8'h04);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ntests++; if (rd_data_o !== 16'd256) begin nfail++;
      $display("FAIL rd_update_edge got %0d want 256", rd_data_o); end
    @(posedge clk); #1;
    ntests++; if (rd_data_o !== 16'd496) begin nfail++;
      $display("FAIL rd_post_update got %0d want 496", rd_data_o); end
    wait_done(n);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_sat();
    test_overrun();
    test_reset_mid();
    test_clear();
    test_readback();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/spike_rate_lp_mc.md
Name: spike_rate_lp_mc

Overview:
- Multi-channel, time-multiplexed successor to the single-channel spike-rate low-pass filter.
- Tracks a per-channel rate estimate y[c] using the recurrence y = y - (y >> alpha[c]) + (spike[c] ? GAIN : 0).
- Updates use one shared datapath that sweeps the channels sequentially on each accepted tick.
- Adds saturation, per-channel alpha, spike accumulation across dropped ticks, overrun and saturation flags, and a registered readback port. Sits between the neuron array spike outputs and the adaptive-threshold/monitor logic.

Parameters:
- N_CH, 8, number of channels (2..64).
- W, 16, rate word width in bits (8..24).
- GAIN, 256, increment per spike; must satisfy GAIN < 2^W.
- AW, 4, alpha field width per channel; shift amount 0..2^AW-1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_en  in  1  tick strobe; a sweep request.
- clear_i  in  1  synchronous clear of all state.
- spike_i  in  N_CH  spike vector, sampled only at ticks.
- alpha_i  in  N_CH*AW  per-channel shift; channel c uses bits [c*AW +: AW].
- rd_ch_i  in  clog2(N_CH)+1  readback channel select.
- rd_data_o  out  W  registered rate of the selected channel.
- busy_o  out  1  sweep in progress.
- done_o  out  1  one-cycle pulse when a sweep completes.
- overrun_o  out  N/A → 1  sticky; a tick arrived while busy.
- sat_o  out  N_CH  sticky per channel; the rate was clamped.

Behaviour:
- Reset: rst_n=0 asynchronously zeroes the rate array, pending/accumulated spike vectors, channel index, busy_o, done_o, overrun_o, sat_o and rd_data_o. Reset mid-sweep aborts the sweep.
- States:
  - IDLE: waiting for a tick.
  - SWEEP: idx runs 0..N_CH-1.
- IDLE + clk_en=1 at edge T:
  - pending <= spike_i | acc; acc <= 0; idx <= 0; busy_o <= 1; go to SWEEP.
- SWEEP, edges T+1..T+N_CH:
  - Each edge updates channel idx with pending[idx] and alpha of idx as sampled at that edge, then increments idx.
  - At edge T+N_CH (idx = N_CH-1): busy_o <= 0, done_o <= 1 for exactly one cycle, return to IDLE.
  - Minimum accepted tick period is N_CH+1 cycles.
- Update arithmetic:
  - leak = y >> alpha.
  - Compute sum = (y - leak) + (pending ? GAIN : 0) in W+1 bits.
  - If sum > 2^W-1, then y <= 2^W-1 and sat_o[idx] <= 1; otherwise y <= sum[W-1:0].
  - y - leak never underflows.
  - alpha=0 gives full leak: y becomes GAIN or 0.
- Tick while busy_o=1:
  - The tick is not started. overrun_o <= 1, acc <= acc | spike_i.
  - The accumulated spikes are ORed into the next accepted tick's pending vector, so no spikes are lost; there is no double-count per channel.
  - The current sweep is unaffected.
- clear_i=1 has priority over everything:
  - Zeroes the rate array, acc, pending, idx, sat_o and overrun_o.
  - Deasserts busy_o, forces IDLE, and suppresses done_o.
  - A tick in the same cycle is ignored.
- Readback:
  - rd_data_o <= y[rd_ch_i] every cycle, so latency is 1.
  - If rd_ch_i >= N_CH, rd_data_o <= 0.
  - Reading a channel at the same edge it is updated returns the pre-update value; the post-update value appears one cycle later.
- Storage is a flop array; no memory macro.

Test Plan:
- N_CH=8, alpha all 4, one tick with spike_i=0x01 → after done_o, ch0=256 and others 0. Two further spike-free ticks → ch0=240, then 225. done_o pulses once per sweep, exactly 8 cycles after each accepted tick.
- Ch3 alpha=15, spike on ch3 every tick → ch3 = 256k for k ≤ 128, then grows by 255 per tick. It then clamps at 65535 and holds 65535 on further spiking ticks, with sat_o[3]=1 and other sat bits 0.
- Tick with spike_i=0x00, second tick 3 cycles later with spike_i=0x80 → overrun_o=1 and the first sweep leaves ch7=0. The next accepted tick with spike_i=0x00 → ch7=256.
- Assert rst_n=0 during SWEEP at idx=4 → all rates, busy_o, done_o and flags read 0 immediately. After release, rd_data_o=0 for all channels.
- Pulse clear_i together with clk_en mid-sweep, with rates nonzero → the sweep is aborted, no done_o, all channels read 0, sat_o and overrun_o cleared, and the tick is ignored.
- rd_ch_i=9 → rd_data_o=0. rd_ch_i=2 held while ch2 updates from 256 to 496 (alpha=4, spike) → 256 at the update edge, 496 on the next cycle.
